// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts a value on start while idle. Produces DIGITS packed BCD digits WIDTH+1 cycles
// later, with a single-cycle done_tick. The bcd output holds the previous result while a
// conversion runs, so a downstream display never shows partial values.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 13,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  ready,
   output logic                  done_tick,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OP   = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Largest value representable in DIGITS decimal digits, plus one.
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

   // Reject configurations whose largest input would overflow the digit field.
   if (((64'd1 << WIDTH) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_bad_params
      $error("bin2bcd_seq: 2**WIDTH-1 does not fit in DIGITS decimal digits");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;

   logic [BW-1:0]    work_adj;
   logic [BW-1:0]    work_sh;
   logic [WIDTH-1:0] shift_sh;

   // Add 3 to every working digit that is 5 or more, so the following shift carries
   // correctly into the next decimal digit.
   always_comb begin
      work_adj = work_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Adjusted digits and binary shift register move left as one chain; the binary MSB
   // enters the LSB of digit 0.
   assign {work_sh, shift_sh} = {work_adj[BW-2:0], shift_q, 1'b0};

   // Next-state for FSM, datapath and the output result register.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = OP;
               shift_d = bin;
               work_d  = '0;
               cnt_d   = CW'(WIDTH);
            end
         end
         OP: begin
            work_d  = work_sh;
            shift_d = shift_sh;
            cnt_d   = cnt_q - CW'(1);
            // Last bit: publish the final shifted value on this same edge.
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               bcd_d   = work_sh;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset abandons any conversion in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   // Outputs come from state and the result register only.
   assign ready     = (state_q == IDLE);
   assign done_tick = (state_q == DONE);
   assign bcd       = bcd_q;

endmodule
